// File: rtl/eth_tx_arbiter_if.sv
// AXI-Stream link bundle used for both arbiter sources and the MAC-facing output.
interface eth_tx_arbiter_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/eth_tx_arbiter.sv
// Packet-granular two-source round-robin arbiter feeding the MAC TX stream,
// with a programmable inter-frame gap and per-source completed-frame counters.
module eth_tx_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int IFG_CYCLES = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  eth_tx_arbiter_if.slave      s0_axis,
  eth_tx_arbiter_if.slave      s1_axis,
  eth_tx_arbiter_if.master     m_axis,
  output logic [1:0]           o_grant,
  output logic                 o_busy,
  output logic [CNT_WIDTH-1:0] o_pkt_cnt0,
  output logic [CNT_WIDTH-1:0] o_pkt_cnt1
);

  localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [IFG_W-1:0] IFG_LOAD = (IFG_CYCLES > 0) ? IFG_W'(IFG_CYCLES - 1) : {IFG_W{1'b0}};
  localparam logic [IFG_W-1:0] IFG_ONE  = {{(IFG_W-1){1'b0}}, 1'b1};
  localparam logic [IFG_W-1:0] IFG_ZERO = {IFG_W{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2,
    ST_IFG    = 2'd3
  } state_e;

  state_e               state_q;
  logic                 last_grant_q;
  logic [IFG_W-1:0]     ifg_cnt_q;
  logic [1:0]           grant_q;
  logic                 busy_q;
  logic [CNT_WIDTH-1:0] cnt0_q;
  logic [CNT_WIDTH-1:0] cnt1_q;

  logic end0_s;
  logic end1_s;

  assign end0_s = s0_axis.tvalid & m_axis.tready & s0_axis.tlast;
  assign end1_s = s1_axis.tvalid & m_axis.tready & s1_axis.tlast;

  assign o_grant    = grant_q;
  assign o_busy     = busy_q;
  assign o_pkt_cnt0 = cnt0_q;
  assign o_pkt_cnt1 = cnt1_q;

  // Arbitration FSM with its registered grant/busy flags and frame counters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      ifg_cnt_q    <= IFG_ZERO;
      grant_q      <= 2'b00;
      busy_q       <= 1'b0;
      cnt0_q       <= {CNT_WIDTH{1'b0}};
      cnt1_q       <= {CNT_WIDTH{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          // On a tie the source that did not own the link last time wins.
          if (s0_axis.tvalid && (!s1_axis.tvalid || last_grant_q)) begin
            state_q      <= ST_GRANT0;
            last_grant_q <= 1'b0;
            grant_q      <= 2'b01;
            busy_q       <= 1'b1;
          end else if (s1_axis.tvalid) begin
            state_q      <= ST_GRANT1;
            last_grant_q <= 1'b1;
            grant_q      <= 2'b10;
            busy_q       <= 1'b1;
          end
        end
        ST_GRANT0: begin
          if (end0_s) begin
            cnt0_q  <= cnt0_q + CNT_ONE;
            grant_q <= 2'b00;
            if (IFG_CYCLES > 0) begin
              state_q   <= ST_IFG;
              ifg_cnt_q <= IFG_LOAD;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        ST_GRANT1: begin
          if (end1_s) begin
            cnt1_q  <= cnt1_q + CNT_ONE;
            grant_q <= 2'b00;
            if (IFG_CYCLES > 0) begin
              state_q   <= ST_IFG;
              ifg_cnt_q <= IFG_LOAD;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        ST_IFG: begin
          if (ifg_cnt_q == IFG_ZERO) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            ifg_cnt_q <= ifg_cnt_q - IFG_ONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= 2'b00;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Zero-latency pass-through from the current owner; everything quiet otherwise.
  always_comb begin
    m_axis.tdata   = {DATA_WIDTH{1'b0}};
    m_axis.tvalid  = 1'b0;
    m_axis.tlast   = 1'b0;
    m_axis.tuser   = 1'b0;
    s0_axis.tready = 1'b0;
    s1_axis.tready = 1'b0;
    case (state_q)
      ST_GRANT0: begin
        m_axis.tdata   = s0_axis.tdata;
        m_axis.tvalid  = s0_axis.tvalid;
        m_axis.tlast   = s0_axis.tlast;
        m_axis.tuser   = s0_axis.tuser;
        s0_axis.tready = m_axis.tready;
      end
      ST_GRANT1: begin
        m_axis.tdata   = s1_axis.tdata;
        m_axis.tvalid  = s1_axis.tvalid;
        m_axis.tlast   = s1_axis.tlast;
        m_axis.tuser   = s1_axis.tuser;
        s1_axis.tready = m_axis.tready;
      end
      default: begin
        m_axis.tvalid  = 1'b0;
        s0_axis.tready = 1'b0;
        s1_axis.tready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench: two arbiter builds (IFG 12 / 16-bit counters and IFG 0 / 4-bit counters)
// driven by directed and random traffic, compared each cycle against a frame-level reference model.
module tb_eth_tx_arbiter;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  s_tdata  [2][2];
  logic        s_tvalid [2][2];
  logic        s_tlast  [2][2];
  logic        s_tuser  [2][2];
  logic        s_tready [2][2];
  logic [7:0]  m_tdata  [2];
  logic        m_tvalid [2];
  logic        m_tlast  [2];
  logic        m_tuser  [2];
  logic        m_tready [2];
  logic [1:0]  grant_obs[2];
  logic        busy_obs [2];
  logic [15:0] cnt_obs  [2][2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int IFG = (g == 0) ? 12 : 0;
    localparam int CW  = (g == 0) ? 16 : 4;
    eth_tx_arbiter_if #(.DATA_WIDTH(8)) s0_if ();
    eth_tx_arbiter_if #(.DATA_WIDTH(8)) s1_if ();
    eth_tx_arbiter_if #(.DATA_WIDTH(8)) m_if ();
    logic [CW-1:0] c0;
    logic [CW-1:0] c1;
    assign s0_if.tdata    = s_tdata[g][0];
    assign s0_if.tvalid   = s_tvalid[g][0];
    assign s0_if.tlast    = s_tlast[g][0];
    assign s0_if.tuser    = s_tuser[g][0];
    assign s_tready[g][0] = s0_if.tready;
    assign s1_if.tdata    = s_tdata[g][1];
    assign s1_if.tvalid   = s_tvalid[g][1];
    assign s1_if.tlast    = s_tlast[g][1];
    assign s1_if.tuser    = s_tuser[g][1];
    assign s_tready[g][1] = s1_if.tready;
    assign m_if.tready    = m_tready[g];
    assign m_tdata[g]     = m_if.tdata;
    assign m_tvalid[g]    = m_if.tvalid;
    assign m_tlast[g]     = m_if.tlast;
    assign m_tuser[g]     = m_if.tuser;
    assign cnt_obs[g][0]  = 16'(c0);
    assign cnt_obs[g][1]  = 16'(c1);
    eth_tx_arbiter #(.DATA_WIDTH(8), .IFG_CYCLES(IFG), .CNT_WIDTH(CW)) u_dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .s0_axis    (s0_if),
      .s1_axis    (s1_if),
      .m_axis     (m_if),
      .o_grant    (grant_obs[g]),
      .o_busy     (busy_obs[g]),
      .o_pkt_cnt0 (c0),
      .o_pkt_cnt1 (c1)
    );
  end

  beat_t       strm [2][$];
  int          ptr  [2];
  int          mptr [2];
  int          mcnt [2];
  int unsigned en_pct [2];
  int unsigned rdy_pct;
  int          owner, last_g, grant_ok, edge_n;
  int          glog [$];
  int          beats [$];
  logic [1:0]  prev_grant;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_frame(input int x, input int len, input int base, input bit rnd);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = rnd ? 8'($urandom) : 8'(base + i);
      b.last = (i == len - 1);
      b.user = 1'($urandom_range(1));
      strm[x].push_back(b);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int x = 0; x < 2; x++) begin
        s_tvalid[d][x] = 1'b0;
        s_tdata[d][x]  = 8'h00;
        s_tlast[d][x]  = 1'b0;
        s_tuser[d][x]  = 1'b0;
      end
      m_tready[d] = 1'b0;
    end
    for (int x = 0; x < 2; x++) begin
      strm[x].delete();
      ptr[x] = 0; mptr[x] = 0; mcnt[x] = 0; en_pct[x] = 0;
    end
    rdy_pct = 100;
    owner = -1; last_g = 1; grant_ok = 0; edge_n = 0;
    glog.delete(); beats.delete(); prev_grant = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drive(input int d);
    for (int x = 0; x < 2; x++) begin
      if (ptr[x] < strm[x].size()) begin
        s_tvalid[d][x] = ($urandom_range(99) < en_pct[x]);
        s_tdata[d][x]  = strm[x][ptr[x]].data;
        s_tlast[d][x]  = strm[x][ptr[x]].last;
        s_tuser[d][x]  = strm[x][ptr[x]].user;
      end else begin
        s_tvalid[d][x] = 1'b0;
        s_tdata[d][x]  = 8'h00;
        s_tlast[d][x]  = 1'b0;
        s_tuser[d][x]  = 1'b0;
      end
    end
    m_tready[d] = ($urandom_range(99) < rdy_pct);
  endtask

  // Frame-level reference: round-robin pick once the link has been free for the gap.
  task automatic model_step(input int d);
    int ifg;
    int mask;
    ifg  = (d == 0) ? 12 : 0;
    mask = (d == 0) ? 16'hFFFF : 16'h000F;
    if (owner < 0) begin
      if (edge_n >= grant_ok) begin
        if (s_tvalid[d][0] && s_tvalid[d][1]) owner = 1 - last_g;
        else if (s_tvalid[d][0]) owner = 0;
        else if (s_tvalid[d][1]) owner = 1;
        if (owner >= 0) last_g = owner;
      end
    end else if (s_tvalid[d][owner] && m_tready[d]) begin
      if (strm[owner][mptr[owner]].last) begin
        mptr[owner]++;
        mcnt[owner] = (mcnt[owner] + 1) & mask;
        grant_ok = edge_n + ifg + 1;
        owner = -1;
      end else begin
        mptr[owner]++;
      end
    end
  endtask

  task automatic sample_and_step(input int d);
    logic [10:0] exp_m;
    logic [1:0]  exp_rdy;
    bit          hs [2];
    @(negedge clk);
    exp_m   = 11'd0;
    exp_rdy = 2'b00;
    if (owner >= 0) begin
      exp_rdy[owner] = m_tready[d];
      if (s_tvalid[d][owner])
        exp_m = {1'b1, strm[owner][mptr[owner]].data, strm[owner][mptr[owner]].last, strm[owner][mptr[owner]].user};
      else
        exp_m = {1'b0, s_tdata[d][owner], s_tlast[d][owner], s_tuser[d][owner]};
    end
    chk("grant", 32'(grant_obs[d]), (owner < 0) ? 32'd0 : (owner == 0) ? 32'd1 : 32'd2);
    chk("busy", 32'(busy_obs[d]), 32'(owner >= 0 || edge_n + 1 < grant_ok));
    chk("m_axis", 32'({m_tvalid[d], m_tdata[d], m_tlast[d], m_tuser[d]}), 32'(exp_m));
    chk("s_tready", 32'({s_tready[d][1], s_tready[d][0]}), 32'(exp_rdy));
    chk("pkt_cnt0", 32'(cnt_obs[d][0]), 32'(mcnt[0]));
    chk("pkt_cnt1", 32'(cnt_obs[d][1]), 32'(mcnt[1]));
    if (m_tvalid[d] && m_tready[d]) beats.push_back(edge_n);
    if (grant_obs[d] != 2'b00 && prev_grant == 2'b00) glog.push_back(int'(grant_obs[d]));
    prev_grant = grant_obs[d];
    for (int x = 0; x < 2; x++) hs[x] = s_tvalid[d][x] && s_tready[d][x];
    @(posedge clk);
    edge_n++;
    model_step(d);
    for (int x = 0; x < 2; x++) if (hs[x]) ptr[x]++;
    #1;
  endtask

  task automatic cycle(input int d);
    drive(d);
    sample_and_step(d);
  endtask

  function automatic bit settled();
    return owner < 0 && mptr[0] >= strm[0].size() && mptr[1] >= strm[1].size() && edge_n + 1 >= grant_ok;
  endfunction

  task automatic drain(input int d, input int maxc);
    int c = 0;
    while (!settled() && c < maxc) begin
      cycle(d);
      c++;
    end
    chk("drain_bound", 32'(c < maxc), 32'd1);
  endtask

  initial begin
    int c;
    // Reset values on both builds.
    do_reset();
    for (int d = 0; d < 2; d++) begin
      chk("rst_grant", 32'(grant_obs[d]), 32'd0);
      chk("rst_busy", 32'(busy_obs[d]), 32'd0);
      chk("rst_m_axis", 32'({m_tvalid[d], m_tdata[d], m_tlast[d], m_tuser[d]}), 32'd0);
      chk("rst_tready", 32'({s_tready[d][1], s_tready[d][0]}), 32'd0);
      chk("rst_cnt", 32'({cnt_obs[d][1], cnt_obs[d][0]}), 32'd0);
    end

    // One 64-byte frame from source 0.
    add_frame(0, 64, 0, 1'b0);
    en_pct[0] = 100;
    drain(0, 200);
    chk("t1_cnt0", 32'(cnt_obs[0][0]), 32'd1);
    chk("t1_beats", 32'(beats.size()), 32'd64);

    // Both sources continuously offering four 10-byte frames each.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      add_frame(0, 10, 0, 1'b1);
      add_frame(1, 10, 0, 1'b1);
    end
    en_pct[0] = 100; en_pct[1] = 100;
    drain(0, 400);
    chk("t2_cnt0", 32'(cnt_obs[0][0]), 32'd4);
    chk("t2_cnt1", 32'(cnt_obs[0][1]), 32'd4);
    chk("t2_ngrants", 32'(glog.size()), 32'd8);
    for (int i = 0; i < glog.size() && i < 8; i++)
      chk("t2_alternate", 32'(glog[i]), (i % 2 == 0) ? 32'd1 : 32'd2);

    // Source 1 with random MAC backpressure and a 5-cycle stall; source 0 arrives in the stall.
    do_reset();
    add_frame(1, 30, 0, 1'b1);
    add_frame(0, 10, 8'h80, 1'b0);
    en_pct[1] = 100; rdy_pct = 50;
    c = 0;
    while (mptr[1] < 8 && c < 100) begin
      cycle(0);
      c++;
    end
    chk("t3_reach", 32'(c < 100), 32'd1);
    en_pct[0] = 100; en_pct[1] = 0;
    repeat (5) cycle(0);
    en_pct[1] = 100;
    drain(0, 400);
    chk("t3_order_n", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      chk("t3_first", 32'(glog[0]), 32'd2);
      chk("t3_second", 32'(glog[1]), 32'd1);
    end
    chk("t3_cnt", 32'({cnt_obs[0][1], cnt_obs[0][0]}), {16'd1, 16'd1});

    // Random mixed traffic.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      add_frame(0, int'($urandom_range(20, 1)), 0, 1'b1);
      add_frame(1, int'($urandom_range(20, 1)), 0, 1'b1);
    end
    en_pct[0] = 70; en_pct[1] = 60; rdy_pct = 70;
    drain(0, 3000);
    chk("t4_cnt", 32'({cnt_obs[0][1], cnt_obs[0][0]}), {16'd6, 16'd6});

    // Reset asserted while byte 20 of a 60-byte frame is on the bus.
    do_reset();
    add_frame(0, 60, 0, 1'b0);
    en_pct[0] = 100;
    c = 0;
    while (mptr[0] < 20 && c < 200) begin
      cycle(0);
      c++;
    end
    chk("t5_reach", 32'(c < 200), 32'd1);
    drive(0);
    #2;
    chk("t5_pre_valid", 32'({m_tvalid[0], m_tdata[0]}), {23'd0, 1'b1, 8'd20});
    rst = 1'b1;
    #1;
    chk("t5_rst_m_axis", 32'({m_tvalid[0], m_tdata[0], m_tlast[0], m_tuser[0]}), 32'd0);
    chk("t5_rst_grant", 32'({busy_obs[0], grant_obs[0]}), 32'd0);
    chk("t5_rst_tready", 32'(s_tready[0][0]), 32'd0);
    chk("t5_rst_cnt0", 32'(cnt_obs[0][0]), 32'd0);
    do_reset();
    add_frame(0, 60, 8'h40, 1'b0);
    en_pct[0] = 100;
    drain(0, 200);
    chk("t5_cnt0", 32'(cnt_obs[0][0]), 32'd1);
    chk("t5_beats", 32'(beats.size()), 32'd60);

    // Zero-gap build: back-to-back single-beat frames from source 0.
    do_reset();
    for (int i = 0; i < 6; i++) add_frame(0, 1, 8'h10 + i, 1'b0);
    en_pct[0] = 100;
    drain(1, 100);
    chk("t6_cnt0", 32'(cnt_obs[1][0]), 32'd6);
    chk("t6_nbeats", 32'(beats.size()), 32'd6);
    for (int i = 1; i < beats.size(); i++)
      chk("t6_spacing", 32'(beats[i] - beats[i-1]), 32'd2);

    // 4-bit counter wrap: 17 frames from source 1.
    do_reset();
    for (int i = 0; i < 17; i++) add_frame(1, int'($urandom_range(2, 1)), 0, 1'b1);
    en_pct[1] = 100; rdy_pct = 80;
    drain(1, 300);
    chk("t7_cnt1_wrap", 32'(cnt_obs[1][1]), 32'd1);
    chk("t7_cnt0", 32'(cnt_obs[1][0]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
